taquito_order_queue: RTL

TAQUITO_ORDER_QUEUE -- requirements
Module: taquito_order_queue

---
 rtl/taquito_order_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/taquito_order_queue.sv
// One-hot flavour order FIFO with ASCII code output and saturating per-flavour served counters.
// Flavour indices are stored, not codes; the code is looked up from the head entry.
module taquito_order_queue #(
  parameter int                    N_FLAV = 4,
  parameter int                    DEPTH  = 8,
  parameter int                    CNT_W  = 8,
  parameter logic [N_FLAV*8-1:0]   CODES  = {8'd68, 8'd70, 8'd80, 8'd67}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_FLAV-1:0]         sel,
  input  logic                      sel_valid,
  output logic                      sel_ready,
  output logic [7:0]                code_out,
  output logic                      code_valid,
  input  logic                      code_ready,
  output logic                      err,
  output logic [$clog2(DEPTH):0]    level,
  input  logic                      clr_counts,
  output logic [N_FLAV*CNT_W-1:0]   count
);

  localparam int IDX_W = $clog2(N_FLAV);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [N_FLAV-1:0] SEL_ONE = 1;

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] lvl;
  logic [CNT_W-1:0] cnt [N_FLAV];

  logic             onehot;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] head;
  logic             push;
  logic             pop;
  logic             wr_en;

  assign sel_ready  = (lvl != LVL_W'(DEPTH));
  assign code_valid = (lvl != '0);
  assign level      = lvl;
  assign push       = sel_valid & sel_ready;
  assign pop        = code_valid & code_ready;
  assign wr_en      = push & onehot;
  assign head       = mem[rd_ptr];

  // x & (x-1) clears the lowest set bit; zero result with x!=0 means exactly one bit set
  always_comb begin
    onehot  = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
    sel_idx = '0;
    for (int i = 0; i < N_FLAV; i++) begin
      if (sel[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    code_out = 8'h00;
    if (code_valid) begin
      for (int i = 0; i < N_FLAV; i++) begin
        if (head == IDX_W'(i)) code_out = CODES[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sel_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
      err    <= 1'b0;
    end else begin
      err <= push & ~onehot;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   lvl <= lvl + LVL_W'(1);
        2'b01:   lvl <= lvl - LVL_W'(1);
        default: lvl <= lvl;
      endcase
    end
  end

  // Clear wins over a same-cycle pop increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FLAV; i++) cnt[i] <= '0;
    end else if (clr_counts) begin
      for (int i = 0; i < N_FLAV; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_FLAV; i++) begin
        if (pop && (head == IDX_W'(i)) && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N_FLAV; g++) begin : g_count
    assign count[CNT_W*g +: CNT_W] = cnt[g];
  end

endmodule
